conv_layer_scheduler: RTL and testbench
=======================================

# conv_layer_scheduler

Sequences a bank of `NUM_CONVS` parallel convolution units that share one input frame. It double-buffers incoming samples from upstream and issues a one-cycle start to all units. It then broadcasts the frame word by word in lockstep, waits for every unit to finish, and presents a single valid/yumi handshake to the downstream layer. It sits between the input sample stream and the layer-1 convolution array. The downstream layer reads the convolution outputs directly from the units.

## Interface
- `NUM_CONVS`, 4: number of convolution units driven in lockstep.
- `INPUT_LAYER_HEIGHT`, 64: samples per channel per frame.
- `KERNEL_WIDTH`, 2: channels per sample (2 = I/Q).
- `WORD_SIZE`, 16: data word width.
- Local constant `FRAME_WORDS` = `INPUT_LAYER_HEIGHT*KERNEL_WIDTH` (128 at defaults).

Ports:
- `clk_i`  in  1  single clock; all state on rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  upstream word valid.
- `ready_o`  out  1  write bank free; accept word.
- `data_i`  in  `WORD_SIZE`  upstream word, signed.
- `conv_start_o`  out  1  one-cycle start pulse to all units.
- `conv_valid_o`  out  1  broadcast word valid.
- `conv_data_o`  out  `WORD_SIZE`  broadcast word.
- `conv_ready_i`  in  `NUM_CONVS`  per-unit ready.
- `conv_valid_i`  in  `NUM_CONVS`  per-unit result valid.
- `conv_yumi_o`  out  1  broadcast result consumed.
- `valid_o`  out  1  all unit results valid.
- `yumi_i`  in  1  downstream consumes results.
- `busy_o`  out  1  FSM not in eIDLE.
- `frames_o`  out  16  completed-frame count; wraps 0xFFFF→0.

## Operation
- Two banks of `FRAME_WORDS` words each. Per-bank full flags `full[1:0]`, plus `wr_bank`/`wr_ptr` and `rd_bank`/`rd_ptr`.
- Write side:
  - `ready_o = !full[wr_bank]`.
  - On `valid_i && ready_o`, the word is stored at `[wr_bank][wr_ptr]` and `wr_ptr` increments.
  - At `wr_ptr == FRAME_WORDS-1`, the handshake sets `full[wr_bank]`, clears `wr_ptr` and toggles `wr_bank`.
- Sequencing FSM states:
  - eIDLE: go to eSTART when `full[rd_bank]`.
  - eSTART: `conv_start_o=1` for exactly one cycle, then go to eSTREAM.
  - eSTREAM:
    - `conv_valid_o=1` and `conv_data_o = bank[rd_bank][rd_ptr]` (combinational read).
    - A broadcast fires only when `conv_valid_o && &conv_ready_i`; it then increments `rd_ptr`.
    - The fire at `rd_ptr == FRAME_WORDS-1` clears `full[rd_bank]`, clears `rd_ptr`, toggles `rd_bank` and goes to eWAIT.
  - eWAIT: go to eDONE when `&conv_valid_i`. A partial `conv_valid_i` is ignored.
  - eDONE:
    - `valid_o=1` and `conv_yumi_o = yumi_i`.
    - On `yumi_i`, `frames_o` increments and the FSM goes to eIDLE.
- `yumi_i` outside eDONE is ignored; `conv_yumi_o` stays 0.
- Simultaneous events:
  - A write completing one bank in the same cycle a stream frees the other bank: both flag updates take effect.
  - The write side may fill the freed bank immediately.
  - Upstream is never stalled by eWAIT/eDONE unless both banks are full.
- `conv_data_o` is stable while `conv_valid_o && !(&conv_ready_i)`; no word is skipped or repeated.
- Reset (any time, including mid-stream):
  - Both full flags, all pointers and `frames_o` clear; FSM returns to eIDLE.
  - Bank contents are don't-care.
  - Units are reset by their own reset path; the integrator asserts it together with `reset_ni`.

## Timing
- Reset values: `conv_start_o`, `conv_valid_o`, `conv_yumi_o`, `valid_o`, `busy_o` = 0; `frames_o` = 0; `ready_o` = 1; `conv_data_o` = don't-care.
- The last write handshake occurs in cycle N. `full` is seen in N+1, with FSM eIDLE→eSTART. `conv_start_o` is high in cycle N+2. The first `conv_valid_o` is in N+3.
- Stream throughput is 1 word/cycle while all units are ready. Minimum eSTREAM duration is `FRAME_WORDS` cycles.
- `valid_o` rises the cycle after `&conv_valid_i` is first sampled in eWAIT. `conv_yumi_o` is combinational from `yumi_i`, the same cycle.
- eDONE→eIDLE→eSTART takes 2 cycles minimum between frames when the next bank is already full.

## Structure
- `conv_sched_pkg`: state enum (eIDLE, eSTART, eSTREAM, eWAIT, eDONE, 3 bits) and the frame-word-count function of height and width.
- Sub-module `frame_pingpong_buf`:
  - Contents: two-bank register array, write pointer/bank, full flags, combinational read port.
  - Controls: `rd_advance` and `rd_release` inputs driven by the FSM.
  - The FSM, handshakes and `frames_o` stay in the top.

## Test plan
- Reset: hold `reset_ni=0` for 3 cycles mid-operation → all outputs take their reset values; `ready_o=1`; `frames_o=0`.
- Single frame: write words 0..127 with units always ready → `conv_start_o` is a one-cycle pulse in N+2, and `conv_data_o` carries 0..127 in order over 128 consecutive cycles.
- Backpressure: drive `conv_ready_i[2]` low on every third cycle → `conv_data_o` is held during stalls, and exactly 128 fires occur with the sequence intact.
- Ping-pong: write frame B (values 1000+i) during frame A streaming, then try frame C → `ready_o` drops to 0 after B completes and reasserts the cycle after A's last fire; B streams second, unchanged.
- Completion: raise `conv_valid_i` bits at staggered cycles 5/9/12/20 and hold `yumi_i` low for 10 cycles → `valid_o` rises only after bit 3 and stays high. Then pulse `yumi_i` → one-cycle `conv_yumi_o`, and `frames_o` goes 0→1.
- Wrap: preload `frames_o=0xFFFF` via 65535 frames (or force) and run one more frame → `frames_o=0`.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types for the convolution-layer scheduler: sequencing states and frame sizing.
package conv_sched_pkg;

   typedef enum logic [2:0] {
      eIDLE,
      eSTART,
      eSTREAM,
      eWAIT,
      eDONE
   } state_e;

   function automatic int frame_words(input int height, input int width);
      return height * width;
   endfunction

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two-bank frame buffer: upstream fills one bank while the scheduler streams the other.
module frame_pingpong_buf #(
   parameter int WORD_SIZE   = 16,
   parameter int FRAME_WORDS = 128
) (
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic                        wr_valid_i,
   output logic                        wr_ready_o,
   input  logic signed [WORD_SIZE-1:0] wr_data_i,
   input  logic                        rd_advance_i,
   input  logic                        rd_release_i,
   output logic                        rd_full_o,
   output logic                        rd_last_o,
   output logic signed [WORD_SIZE-1:0] rd_data_o
);

   localparam int PTR_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_WORDS - 1);

   logic signed [WORD_SIZE-1:0] mem_q [2][FRAME_WORDS];
   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             wr_fire;

   assign wr_ready_o = !full_q[wr_bank_q];
   assign wr_fire    = wr_valid_i && wr_ready_o;
   assign rd_full_o  = full_q[rd_bank_q];
   assign rd_last_o  = (rd_ptr_q == LAST_PTR);
   assign rd_data_o  = mem_q[rd_bank_q][rd_ptr_q];

   // A write can never target the bank being released (it is full), so both flag edits coexist.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      wr_ptr_d  = wr_ptr_q;
      rd_bank_d = rd_bank_q;
      rd_ptr_d  = rd_ptr_q;
      if (wr_fire) begin
         if (wr_ptr_q == LAST_PTR) begin
            full_d[wr_bank_q] = 1'b1;
            wr_ptr_d          = '0;
            wr_bank_d         = !wr_bank_q;
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end
      if (rd_release_i) begin
         full_d[rd_bank_q] = 1'b0;
         rd_ptr_d          = '0;
         rd_bank_d         = !rd_bank_q;
      end else if (rd_advance_i) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_bank_q <= 1'b0;
         rd_ptr_q  <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_bank_q <= rd_bank_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_fire) begin
         mem_q[wr_bank_q][wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Feeds one buffered input frame to a bank of lockstep convolution units and
// hands the combined result to the next layer with a single valid/yumi handshake.
module conv_layer_scheduler
   import conv_sched_pkg::*;
#(
   parameter int NUM_CONVS          = 4,
   parameter int INPUT_LAYER_HEIGHT = 64,
   parameter int KERNEL_WIDTH       = 2,
   parameter int WORD_SIZE          = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic signed [WORD_SIZE-1:0] data_i,
   output logic                        conv_start_o,
   output logic                        conv_valid_o,
   output logic signed [WORD_SIZE-1:0] conv_data_o,
   input  logic [NUM_CONVS-1:0]        conv_ready_i,
   input  logic [NUM_CONVS-1:0]        conv_valid_i,
   output logic                        conv_yumi_o,
   output logic                        valid_o,
   input  logic                        yumi_i,
   output logic                        busy_o,
   output logic [15:0]                 frames_o
);

   localparam int FRAME_WORDS = frame_words(INPUT_LAYER_HEIGHT, KERNEL_WIDTH);

   state_e      state_q, state_d;
   logic [15:0] frames_q, frames_d;
   logic        rd_full, rd_last, fire;

   frame_pingpong_buf #(
      .WORD_SIZE  (WORD_SIZE),
      .FRAME_WORDS(FRAME_WORDS)
   ) u_buf (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .wr_valid_i  (valid_i),
      .wr_ready_o  (ready_o),
      .wr_data_i   (data_i),
      .rd_advance_i(fire && !rd_last),
      .rd_release_i(fire && rd_last),
      .rd_full_o   (rd_full),
      .rd_last_o   (rd_last),
      .rd_data_o   (conv_data_o)
   );

   always_comb begin
      state_d      = state_q;
      frames_d     = frames_q;
      conv_start_o = 1'b0;
      conv_valid_o = 1'b0;
      conv_yumi_o  = 1'b0;
      valid_o      = 1'b0;
      fire         = 1'b0;
      unique case (state_q)
         eIDLE: begin
            if (rd_full) state_d = eSTART;
         end
         eSTART: begin
            conv_start_o = 1'b1;
            state_d      = eSTREAM;
         end
         eSTREAM: begin
            conv_valid_o = 1'b1;
            fire         = &conv_ready_i;
            if (fire && rd_last) state_d = eWAIT;
         end
         eWAIT: begin
            if (&conv_valid_i) state_d = eDONE;
         end
         eDONE: begin
            valid_o     = 1'b1;
            conv_yumi_o = yumi_i;
            if (yumi_i) begin
               frames_d = frames_q + 16'd1;
               state_d  = eIDLE;
            end
         end
         default: state_d = eIDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= eIDLE;
         frames_q <= '0;
      end else begin
         state_q  <= state_d;
         frames_q <= frames_d;
      end
   end

   assign busy_o   = (state_q != eIDLE);
   assign frames_o = frames_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Scoreboard bench for conv_layer_scheduler: writers push expected words, a monitor checks every broadcast.
module tb_conv_layer_scheduler;

   localparam int FW = 128;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               valid_i;
   logic               ready_o;
   logic signed [15:0] data_i;
   logic               conv_start_o, conv_valid_o, conv_yumi_o, valid_o, busy_o;
   logic signed [15:0] conv_data_o;
   logic [3:0]         conv_ready_i, conv_valid_i;
   logic               yumi_i;
   logic [15:0]        frames_o;

   conv_layer_scheduler dut (
      .clk_i       (clk),
      .reset_ni    (rst_n),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_i      (data_i),
      .conv_start_o(conv_start_o),
      .conv_valid_o(conv_valid_o),
      .conv_data_o (conv_data_o),
      .conv_ready_i(conv_ready_i),
      .conv_valid_i(conv_valid_i),
      .conv_yumi_o (conv_yumi_o),
      .valid_o     (valid_o),
      .yumi_i      (yumi_i),
      .busy_o      (busy_o),
      .frames_o    (frames_o)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          exp_q[$];
   logic [15:0] exp_frames = 16'd0;
   bit          bp_en = 1'b0;

   int fires_total = 0, frame_fires = 0, stall_cnt = 0;
   int start_cyc = 0, first_fire_cyc = 0, last_fire_cyc = 0;
   bit prev_start = 1'b0, prev_cvalid = 1'b0, stall_pend = 1'b0;
   int held = 0;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      conv_ready_i = (bp_en && (cyc % 3 == 0)) ? 4'b1011 : 4'b1111;
   end

   // Monitor: every broadcast fire pops one expected word; stalls must hold the word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (conv_start_o) begin
            chk("start_pulse_width", int'(prev_start), 0);
            start_cyc   = cyc;
            frame_fires = 0;
         end
         if (conv_valid_o && !prev_cvalid) chk("first_valid_latency", cyc, start_cyc + 1);
         if (conv_valid_o) begin
            if (stall_pend) chk("stall_hold", int'(conv_data_o), held);
            if (&conv_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_fire: got %0d expected no broadcast", conv_data_o);
               end else begin
                  chk("stream_word", int'(conv_data_o), exp_q.pop_front());
               end
               if (frame_fires == 0) first_fire_cyc = cyc;
               frame_fires++;
               fires_total++;
               last_fire_cyc = cyc;
               stall_pend    = 1'b0;
            end else begin
               stall_pend = 1'b1;
               held       = int'(conv_data_o);
               stall_cnt++;
            end
         end
         prev_start  = conv_start_o;
         prev_cvalid = conv_valid_o;
      end else begin
         prev_start  = 1'b0;
         prev_cvalid = 1'b0;
         stall_pend  = 1'b0;
      end
   end

   // Call at posedge+#1; leaves inputs idle at posedge+#1 after the last handshake.
   task automatic write_frame(input int base, output int first_c, output int last_c, output int stalls);
      int i = 0;
      int guard = 0;
      stalls  = 0;
      first_c = 0;
      last_c  = 0;
      while (i < FW && guard < 3000) begin
         valid_i = 1'b1;
         data_i  = 16'(base + i);
         @(negedge clk);
         if (ready_o) begin
            exp_q.push_back(base + i);
            if (i == 0) first_c = cyc;
            last_c = cyc;
            i++;
         end else begin
            stalls++;
            guard++;
         end
         @(posedge clk);
         #1;
      end
      valid_i = 1'b0;
      if (guard >= 3000) begin
         n_tests++;
         n_fail++;
         $display("FAIL write_timeout: got %0d words expected %0d", i, FW);
      end
   endtask

   task automatic complete_frame(input int target, input int d0, input int d1, input int d2,
                                 input int d3, input int hold, output int lf);
      int guard = 0;
      int dmax;
      lf = 0;
      while (fires_total < target && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (fires_total < target) begin
         n_tests++;
         n_fail++;
         $display("FAIL stream_timeout: got %0d fires expected %0d", fires_total, target);
         return;
      end
      lf   = last_fire_cyc;
      dmax = d0;
      if (d1 > dmax) dmax = d1;
      if (d2 > dmax) dmax = d2;
      if (d3 > dmax) dmax = d3;
      for (int t = 1; t <= dmax + hold; t++) begin
         @(posedge clk);
         #1;
         conv_valid_i = {t >= d3, t >= d2, t >= d1, t >= d0};
         @(negedge clk);
         chk("valid_o_wait", int'(valid_o), int'(t >= dmax + 1));
         chk("conv_yumi_idle", int'(conv_yumi_o), 0);
      end
      @(posedge clk);
      #1;
      yumi_i = 1'b1;
      @(negedge clk);
      chk("conv_yumi_pulse", int'(conv_yumi_o), 1);
      chk("valid_o_done", int'(valid_o), 1);
      exp_frames = exp_frames + 16'd1;
      @(posedge clk);
      #1;
      yumi_i       = 1'b0;
      conv_valid_i = '0;
      @(negedge clk);
      chk("conv_yumi_after", int'(conv_yumi_o), 0);
      chk("valid_o_after", int'(valid_o), 0);
      chk("frames_o", int'(frames_o), int'(exp_frames));
   endtask

   task automatic check_reset_outputs();
      chk("rst_conv_start", int'(conv_start_o), 0);
      chk("rst_conv_valid", int'(conv_valid_o), 0);
      chk("rst_conv_yumi", int'(conv_yumi_o), 0);
      chk("rst_valid_o", int'(valid_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_frames", int'(frames_o), 0);
      chk("rst_ready", int'(ready_o), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, fl, st, lf, t0, s0;
      int a_f, a_l, b_f, b_l, c_f, c_l, a_st, b_st, c_st, a_lf, b_lf, c_lf;

      rst_n        = 1'b0;
      valid_i      = 1'b0;
      data_i       = '0;
      conv_ready_i = 4'hF;
      conv_valid_i = '0;
      yumi_i       = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs();
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single frame, units always ready; a stray yumi mid-stream must be ignored.
      @(posedge clk);
      #1;
      t0 = fires_total;
      fork
         write_frame(0, f0, fl, st);
         complete_frame(t0 + FW, 1, 1, 1, 1, 0, lf);
         begin
            int g = 0;
            while (fires_total < t0 + 40 && g < 2000) begin
               @(negedge clk);
               g++;
            end
            @(posedge clk);
            #1;
            yumi_i = 1'b1;
            @(negedge clk);
            chk("yumi_ignored_stream", int'(conv_yumi_o), 0);
            chk("valid_o_stream", int'(valid_o), 0);
            @(posedge clk);
            #1;
            yumi_i = 1'b0;
         end
      join
      chk("start_at_N_plus_2", start_cyc, fl + 2);
      chk("first_fire_N_plus_3", first_fire_cyc, fl + 3);
      chk("stream_contiguous", last_fire_cyc - first_fire_cyc, FW - 1);
      chk("single_fires", fires_total - t0, FW);
      chk("single_queue_empty", exp_q.size(), 0);

      // Backpressure on unit 2 every third cycle.
      @(posedge clk);
      #1;
      t0    = fires_total;
      s0    = stall_cnt;
      bp_en = 1'b1;
      fork
         write_frame(500, f0, fl, st);
         complete_frame(t0 + FW, 1, 1, 1, 1, 0, lf);
      join
      bp_en = 1'b0;
      chk("bp_fires", fires_total - t0, FW);
      chk("bp_stalls_seen", int'(stall_cnt > s0), 1);
      chk("bp_span", last_fire_cyc - first_fire_cyc, FW - 1 + (stall_cnt - s0));
      chk("bp_queue_empty", exp_q.size(), 0);

      // Ping-pong: A then B back to back, C blocked until A's last fire frees a bank.
      @(posedge clk);
      #1;
      t0 = fires_total;
      fork
         begin
            write_frame(2000, a_f, a_l, a_st);
            write_frame(1000, b_f, b_l, b_st);
            write_frame(3000, c_f, c_l, c_st);
         end
         begin
            complete_frame(t0 + FW, 1, 1, 1, 1, 0, a_lf);
            complete_frame(t0 + 2 * FW, 1, 1, 1, 1, 0, b_lf);
            complete_frame(t0 + 3 * FW, 1, 1, 1, 1, 0, c_lf);
         end
      join
      chk("pp_b_not_stalled", b_st, 0);
      chk("pp_b_back_to_back", b_f, a_l + 1);
      chk("pp_c_stall_cycles", c_st, 2);
      chk("pp_c_after_a_last", c_f, a_lf + 1);
      chk("pp_a_last_fire", a_lf, a_l + 130);
      chk("pp_queue_empty", exp_q.size(), 0);

      // Staggered unit completion and a delayed downstream yumi.
      @(posedge clk);
      #1;
      t0 = fires_total;
      fork
         write_frame(4000, f0, fl, st);
         complete_frame(t0 + FW, 5, 9, 12, 20, 10, lf);
      join
      chk("stagger_queue_empty", exp_q.size(), 0);

      // Reset in the middle of a stream.
      @(posedge clk);
      #1;
      t0 = fires_total;
      write_frame(6000, f0, fl, st);
      begin
         int g = 0;
         while (fires_total < t0 + 20 && g < 2000) begin
            @(negedge clk);
            g++;
         end
      end
      chk("midstream_busy", int'(busy_o), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs();
      end
      exp_q.delete();
      exp_frames = 16'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", int'(busy_o), 0);
         chk("post_rst_ready", int'(ready_o), 1);
      end

      // Frame counter wrap from 0xFFFF.
      @(posedge clk);
      #1;
      force dut.frames_q = 16'hFFFF;
      @(posedge clk);
      @(posedge clk);
      #1;
      release dut.frames_q;
      @(negedge clk);
      chk("frames_preload", int'(frames_o), 16'hFFFF);
      exp_frames = 16'hFFFF;
      @(posedge clk);
      #1;
      t0 = fires_total;
      fork
         write_frame(-100, f0, fl, st);
         complete_frame(t0 + FW, 2, 2, 3, 1, 2, lf);
      join
      chk("frames_wrapped", int'(frames_o), 0);
      chk("wrap_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
